// File: rtl/regfile_multiport_pkg.sv
// regfile_multiport shared definitions: FSM encodings, defaults
// and port-slice helpers used by the register file and its read mux.
package regfile_multiport_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    // Low bit of slice k in a packed bus of w-bit fields.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// regfile_multiport bus: packed read ports, two write ports
// and the ready flag that marks the end of the clear sweep.
interface regfile_multiport_if
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     ready;

    modport master (
        output rd_addr,
        output wr0_en,
        output wr0_addr,
        output wr0_data,
        output wr1_en,
        output wr1_addr,
        output wr1_data,
        input  rd_data,
        input  ready
    );

    modport slave (
        input  rd_addr,
        input  wr0_en,
        input  wr0_addr,
        input  wr0_data,
        input  wr1_en,
        input  wr1_addr,
        input  wr1_data,
        output rd_data,
        output ready
    );

endinterface

// File: rtl/regfile_read_mux.sv
// regfile_read_mux: resolves one read port from the hardwired zero,
// the two same-cycle write ports and the stored entry.
module regfile_read_mux
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic [DATA_W-1:0] data
);

    logic is_zero;
    logic hit0;
    logic hit1;

    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit1    = (BYPASS != 0) && wr1_en && (wr1_addr == addr);
    assign hit0    = (BYPASS != 0) && wr0_en && (wr0_addr == addr);

    // Priority: zero reg, clear sweep, wr1 bypass, wr0 bypass, storage.
    always_comb begin
        data = mem_data;
        if (is_zero) begin
            data = '0;
        end else if (!run) begin
            data = '0;
        end else if (hit1) begin
            data = wr1_data;
        end else if (hit0) begin
            data = wr0_data;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x DATA_W register file with NUM_RD read
// ports, two write ports, bypass, optional zero reg and clear sweep.
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input logic                clock,
    input logic                reset,
    regfile_multiport_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    rf_state_e         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              ready_q;
    logic              run;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              wr0_nz;
    logic              wr1_nz;

    assign run      = (state == RF_RUN);
    assign bus.ready = ready_q;

    assign wr0_nz = (ZERO_REG == 0) || (bus.wr0_addr != '0);
    assign wr1_nz = (ZERO_REG == 0) || (bus.wr1_addr != '0);
    assign wr1_ok = run && bus.wr1_en && wr1_nz;
    // wr1 wins a same-address collision, so wr0 is simply dropped.
    assign wr0_ok = run && bus.wr0_en && wr0_nz &&
                    !(wr1_ok && (bus.wr1_addr == bus.wr0_addr));

    // Control FSM: clear sweep after reset, then normal operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state)
                RF_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state   <= RF_RUN;
                        ready_q <= 1'b1;
                    end
                end
                RF_RUN: begin
                    clr_cnt <= clr_cnt;
                end
                default: begin
                    state   <= RF_CLEAR;
                    clr_cnt <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: sweep zeroes during CLEAR, ports write in RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!run) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (wr0_ok) begin
                    mem[bus.wr0_addr] <= bus.wr0_data;
                end
                if (wr1_ok) begin
                    mem[bus.wr1_addr] <= bus.wr1_data;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = bus.rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
        assign bus.rd_data[slice_lo(k, DATA_W) +: DATA_W] = data;

        regfile_read_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_mux (
            .run      (run),
            .addr     (addr),
            .mem_data (mem[addr]),
            .wr0_en   (bus.wr0_en),
            .wr0_addr (bus.wr0_addr),
            .wr0_data (bus.wr0_data),
            .wr1_en   (bus.wr1_en),
            .wr1_addr (bus.wr1_addr),
            .wr1_data (bus.wr1_data),
            .data     (data)
        );
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the processor's register file. Provides DEPTH×DATA_W storage with NUM_RD combinational read ports, two write ports (write-back and a second retire path), same-cycle write-to-read bypass, an optional hardwired-zero R0, and a reset-triggered clear sweep that zeroes every entry. Sits in the decode stage: the read ports feed the operand latches, and the write ports take data from write-back.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports.
- ZERO_REG, 1: when 1, entry 0 reads as 0 and writes to it are discarded.
- BYPASS, 1: when 1, a read of an address being written this cycle returns the write data.

Ports:
- clock  in  1  system clock; rising edge active.
- reset  in  1  synchronous, active-high; starts the clear sweep.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies slice k.
- rd_data  out  NUM_RD*DATA_W  packed read data; port k occupies slice k.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- ready  out  1  high when the file accepts writes and returns stored data.

## Operation
- FSM states: CLEAR and RUN.
- Any rising edge with reset=1:
  - state←CLEAR, clr_cnt←0, ready←0.
  - Memory is not written on that edge.
- CLEAR with reset=0: each edge writes mem[clr_cnt]←0 and increments clr_cnt.
  - On the edge with clr_cnt==DEPTH-1: state←RUN, ready←1.
- While in CLEAR:
  - wr0/wr1 are ignored entirely.
  - All rd_data slices drive 0.
- RUN: on each edge, for each enabled write port with addr≠0 (or any addr when ZERO_REG=0): mem[addr]←data.
- Both ports enabled to the same address: wr1 wins and wr0 is dropped; no error is flagged.
- Reads are combinational from mem[rd_addr_k]. Resolution order for each port k:
  1. ZERO_REG=1 and rd_addr_k==0 → 0.
  2. BYPASS=1, RUN, wr1_en and wr1_addr==rd_addr_k → wr1_data.
  3. BYPASS=1, RUN, wr0_en and wr0_addr==rd_addr_k → wr0_data.
  4. Otherwise → mem[rd_addr_k].
- BYPASS=0: a read returns the pre-write value in the write cycle and the new value from the next cycle.
- Widths: clr_cnt is ADDR_W bits. The terminal test is an equality compare, so there is no wrap-around into RUN early.

## Timing
- Reset values:
  - ready=0, state=CLEAR, clr_cnt=0.
  - rd_data=0 for the whole of CLEAR.
- Clear latency: ready rises exactly DEPTH rising edges after the first edge sampled with reset=0 (32 edges at default parameters).
- Reset asserted mid-sweep restarts from clr_cnt=0. Entries already cleared stay 0.
- Reset held high: stays in CLEAR with clr_cnt=0 and ready=0.
- Write latency: a write is visible in storage after 1 edge. With BYPASS=1 the new value is visible combinationally in the same cycle.
- Read path: zero cycles, no registered output.
- Writes presented on the edge where ready first rises are not accepted, because that edge still belongs to CLEAR.

## Structure
- Shared header regfile.vh holds:
  - FSM state encodings RF_CLEAR and RF_RUN.
  - Default parameter values.
  - Port-slice index macros.
- This header sits alongside control.vh.
- One sub-module, regfile_read_mux, is instantiated NUM_RD times. It implements the zero/bypass/storage resolution for a single port.
- Storage is a reg array [0:DEPTH-1]; no vendor RAM primitive.

## Test plan
- Reset sweep:
  - Stimulus: assert reset for 2 edges, then release.
  - Required: ready=0 and rd_data=0 for 32 edges; ready=1 on edge 32; every register reads 0.
- Basic write/read:
  - Stimulus: wr0 R2←0xDEEDDEED, next cycle wr0 R5←0xAAAADDDD, then read rs=R5, rt=R2.
  - Required: 0xAAAADDDD and 0xDEEDDEED.
- Bypass:
  - Stimulus: wr0 R7←0xBEEFDEED with rd_addr0=R7 in the same cycle.
  - Required: rd_data0=0xBEEFDEED in that cycle.
  - Repeat with BYPASS=0: old value 0 in that cycle, 0xBEEFDEED in the next.
- Zero register and conflict:
  - Stimulus A: write R0←0xFFFFFFFF.
  - Required A: R0 reads 0.
  - Stimulus B: wr0 R3←0x11111111 and wr1 R3←0x22222222 in one cycle.
  - Required B: R3=0x22222222.
- Reset mid-sweep:
  - Stimulus: reassert reset at clr_cnt=10 after R2 was written with 0xDEEDDEED.
  - Required: ready rises 32 edges after release; R2 reads 0.
  - Writes attempted during CLEAR are lost.
- Parameter sweep:
  - Configuration: DATA_W=16, ADDR_W=3, NUM_RD=4.
  - Required: clear completes in 8 edges; four simultaneous reads of R1, R2, R3, R4 return 0x0001, 0x0002, 0x0003, 0x0004 after those writes.
